// File: rtl/div_iter_unit_pkg.sv
// Shared execute-stage definitions for the iterative divider.
package div_iter_unit_pkg;

    // Default operand/result width of the execute-stage datapath.
    localparam int DIV_WIDTH = 32;

    // Quotient forced out on a divide by zero.
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = '1;

    // Divider control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

endpackage : div_iter_unit_pkg

// File: rtl/div_iter_unit_if.sv
// Request/response bundle between pipeline control and the divider.
interface div_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             div_start;
    logic             div_signed;
    logic             div_cancel;
    logic [WIDTH-1:0] div_src1;
    logic [WIDTH-1:0] div_src2;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;

    // Pipeline side: issues requests, observes status and results.
    modport master (
        output div_start, div_signed, div_cancel, div_src1, div_src2,
        input  div_busy, div_done, div_quotient, div_remainder
    );

    // Divider side.
    modport slave (
        input  div_start, div_signed, div_cancel, div_src1, div_src2,
        output div_busy, div_done, div_quotient, div_remainder
    );
endinterface : div_iter_unit_if

// File: rtl/div_iter_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// compare against the divisor, conditionally subtract.
module div_iter_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] divisor_i,
    input  logic             dvd_bit_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] partial;
    logic [WIDTH:0] dsr_ext;

    // The compare runs on WIDTH+1 bits so the shifted-out top bit of the
    // remainder is never lost. When the compare succeeds the difference is
    // below the divisor, so the low WIDTH bits of the subtraction are exact.
    always_comb begin
        partial = {rem_i, dvd_bit_i};
        dsr_ext = {1'b0, divisor_i};
        q_bit_o = (partial >= dsr_ext);
        rem_o   = q_bit_o ? (partial[WIDTH-1:0] - divisor_i) : partial[WIDTH-1:0];
    end

endmodule : div_iter_step

// File: rtl/div_iter_unit.sv
// Multi-cycle restoring divider (DIV/DIVU) for the execute stage.
// Works on operand magnitudes and fixes signs in a final cycle; holds
// div_busy while running so the pipeline can stall.
module div_iter_unit
    import div_iter_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              resetn,
    div_iter_unit_if.slave    bus
);

    div_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] dsr_q;      // divisor magnitude
    logic [WIDTH-1:0] rem_q;      // running partial remainder
    logic [WIDTH-1:0] quo_q;      // quotient bits shifted in LSB side
    logic [WIDTH-1:0] src1_q;     // original dividend, returned on divide by zero
    logic             neg_quo_q;
    logic             neg_rem_q;
    logic             zero_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;

    logic             src1_neg;
    logic             src2_neg;
    logic [WIDTH-1:0] dvd_mag_d;
    logic [WIDTH-1:0] dsr_mag_d;
    logic [WIDTH-1:0] quo_fix_d;
    logic [WIDTH-1:0] rem_fix_d;
    logic [WIDTH-1:0] step_rem;
    logic             step_qbit;

    div_iter_step #(.WIDTH(WIDTH)) u_step (
        .rem_i     (rem_q),
        .divisor_i (dsr_q),
        .dvd_bit_i (dvd_q[WIDTH-1]),
        .rem_o     (step_rem),
        .q_bit_o   (step_qbit)
    );

    // Operand magnitudes at issue, and sign-corrected results for FIX.
    // The most negative dividend negates to itself, which is what makes the
    // signed-overflow case come out as 0x8000_0000 / 0.
    always_comb begin
        src1_neg  = bus.div_signed & bus.div_src1[WIDTH-1];
        src2_neg  = bus.div_signed & bus.div_src2[WIDTH-1];
        dvd_mag_d = src1_neg ? (~bus.div_src1 + 1'b1) : bus.div_src1;
        dsr_mag_d = src2_neg ? (~bus.div_src2 + 1'b1) : bus.div_src2;
        quo_fix_d = zero_q ? {WIDTH{1'b1}} : (neg_quo_q ? (~quo_q + 1'b1) : quo_q);
        rem_fix_d = zero_q ? src1_q : (neg_rem_q ? (~rem_q + 1'b1) : rem_q);
    end

    // Control FSM with registered busy/done/result outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            src1_q      <= '0;
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            zero_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    // A simultaneous cancel drops the request.
                    if (bus.div_start && !bus.div_cancel) begin
                        dvd_q     <= dvd_mag_d;
                        dsr_q     <= dsr_mag_d;
                        src1_q    <= bus.div_src1;
                        neg_rem_q <= src1_neg;
                        neg_quo_q <= src1_neg ^ src2_neg;
                        zero_q    <= (bus.div_src2 == '0);
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end
                CALC: begin
                    if (bus.div_cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        rem_q <= step_rem;
                        quo_q <= {quo_q[WIDTH-2:0], step_qbit};
                        dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(WIDTH - 1)) begin
                            state_q <= FIX;
                        end
                    end
                end
                FIX: begin
                    if (bus.div_cancel) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        quotient_q  <= quo_fix_d;
                        remainder_q <= rem_fix_d;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.div_busy      = busy_q;
    assign bus.div_done      = done_q;
    assign bus.div_quotient  = quotient_q;
    assign bus.div_remainder = remainder_q;

endmodule : div_iter_unit

// File: tb/tb_div_iter_unit.sv
// Self-checking bench for div_iter_unit: expected results are queued when a
// request is issued and compared when div_done fires.
module tb_div_iter_unit;
    import div_iter_unit_pkg::*;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
    } exp_t;

    logic clk;
    logic resetn;
    int   cyc;
    int   tests_run;
    int   tests_failed;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_iter_unit_if #(.WIDTH(32)) bus ();

    div_iter_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: truncating division, remainder takes dividend sign.
    task automatic model(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r);
        if (b == 32'd0) begin
            q = DIV_ZERO_Q;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // Present one request for a single cycle; optionally expect a result.
    task automatic start_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                             input bit expect_it);
        exp_t e;
        @(negedge clk);
        bus.div_start  = 1'b1;
        bus.div_signed = s;
        bus.div_src1   = a;
        bus.div_src2   = b;
        if (expect_it) begin
            model(s, a, b, e.q, e.r);
            e.cyc = cyc + 34;
            sb_q.push_back(e);
            $display("[TB] issue %s %h / %h -> q=%h r=%h", s ? "DIV " : "DIVU", a, b, e.q, e.r);
        end
        @(negedge clk);
        bus.div_start = 1'b0;
    endtask

    // Wait, with a cycle budget, until every queued result has been seen.
    task automatic wait_drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            check_eq("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    // Result monitor: every div_done must match the oldest expectation.
    always @(negedge clk) begin
        if (resetn && bus.div_done) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("quotient", bus.div_quotient, mon_e.q);
                check_eq("remainder", bus.div_remainder, mon_e.r);
                check_eq("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                check_eq("busy_in_done", {31'd0, bus.div_busy}, 32'd1);
                last_q = mon_e.q;
                last_r = mon_e.r;
                $display("[TB] done q=%h r=%h at cycle %0d", bus.div_quotient, bus.div_remainder, cyc);
            end
        end
    end

    initial begin
        bit got;
        logic [31:0] ra, rb;
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        last_q       = '0;
        last_r       = '0;
        resetn         = 1'b0;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_cancel = 1'b0;
        bus.div_src1   = '0;
        bus.div_src2   = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_busy", {31'd0, bus.div_busy}, 32'd0);
        check_eq("rst_done", {31'd0, bus.div_done}, 32'd0);
        check_eq("rst_q", bus.div_quotient, 32'd0);
        check_eq("rst_r", bus.div_remainder, 32'd0);
        resetn = 1'b1;
        @(negedge clk);

        // Basic unsigned divide with busy timing.
        start_div(1'b0, 32'd100, 32'd7, 1'b1);
        check_eq("busy_after_start", {31'd0, bus.div_busy}, 32'd1);
        wait_drain();
        check_eq("busy_after_done", {31'd0, bus.div_busy}, 32'd0);

        // Signed cases, overflow and divide by zero.
        start_div(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);          wait_drain();
        start_div(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);          wait_drain();
        start_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);  wait_drain();
        start_div(1'b0, 32'h0000_1234, 32'd0, 1'b1);          wait_drain();
        start_div(1'b1, 32'hFFFF_FF00, 32'd0, 1'b1);          wait_drain();
        start_div(1'b0, 32'hFFFF_FFFF, 32'd1, 1'b1);          wait_drain();

        // Random operands in both modes.
        for (int i = 0; i < 8; i++) begin
            ra = $urandom;
            rb = (i % 3 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
            start_div(1'(i % 2), ra, rb, 1'b1);
            wait_drain();
        end

        // Cancel mid-CALC; a start while busy is ignored.
        start_div(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (3) @(negedge clk);
        bus.div_start = 1'b1; bus.div_src1 = 32'd9; bus.div_src2 = 32'd3;
        @(negedge clk);
        bus.div_start = 1'b0;
        repeat (4) @(negedge clk);
        bus.div_cancel = 1'b1;
        @(negedge clk);
        bus.div_cancel = 1'b0;
        check_eq("cancel_busy", {31'd0, bus.div_busy}, 32'd0);
        check_eq("cancel_hold_q", bus.div_quotient, last_q);
        check_eq("cancel_hold_r", bus.div_remainder, last_r);
        repeat (40) @(negedge clk);
        check_eq("cancel_idle_busy", {31'd0, bus.div_busy}, 32'd0);
        start_div(1'b0, 32'd9, 32'd3, 1'b1);
        wait_drain();

        // Start and cancel together in IDLE: request dropped.
        @(negedge clk);
        bus.div_start = 1'b1; bus.div_cancel = 1'b1;
        bus.div_src1 = 32'd50; bus.div_src2 = 32'd5;
        @(negedge clk);
        bus.div_start = 1'b0; bus.div_cancel = 1'b0;
        check_eq("start_cancel_busy", {31'd0, bus.div_busy}, 32'd0);
        repeat (40) @(negedge clk);

        // Back-to-back: start in DONE ignored, start in next IDLE accepted.
        start_div(1'b0, 32'd50, 32'd5, 1'b1);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.div_done) got = 1'b1;
        end
        check_eq("b2b_done_seen", {31'd0, got}, 32'd1);
        bus.div_start = 1'b1; bus.div_signed = 1'b0;
        bus.div_src1 = 32'd77; bus.div_src2 = 32'd7;
        @(negedge clk);
        check_eq("b2b_start_in_done_ignored", {31'd0, bus.div_busy}, 32'd0);
        mon_e.q = 32'd11; mon_e.r = 32'd0; mon_e.cyc = cyc + 34;
        sb_q.push_back(mon_e);
        $display("[TB] issue DIVU 0000004d / 00000007 -> q=0000000b r=00000000");
        @(negedge clk);
        bus.div_start = 1'b0;
        check_eq("b2b_busy", {31'd0, bus.div_busy}, 32'd1);
        wait_drain();
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC clears everything before the next edge.
        start_div(1'b0, 32'd100, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check_eq("arst_busy", {31'd0, bus.div_busy}, 32'd0);
        check_eq("arst_done", {31'd0, bus.div_done}, 32'd0);
        check_eq("arst_q", bus.div_quotient, 32'd0);
        check_eq("arst_r", bus.div_remainder, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        start_div(1'b1, 32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_div_iter_unit

// File: doc/div_iter_unit.md
Name: div_iter_unit

Overview:
- Multi-cycle 32-bit integer divider in the execute stage.
- Sits beside the execute-stage ALU and replaces its single-cycle "/" and "%" path for DIV/DIVU.
- Takes the same operand buses the ALU uses. Produces quotient (LO) and remainder (HI) for the HI/LO write-back path.
- Holds `div_busy` high so the pipeline control can stall while the divide runs.

Parameters:
- WIDTH, 32, operand and result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- div_start  input  1  request a divide; sampled only in IDLE.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- div_cancel  input  1  flush from pipeline control (exception or branch kill).
- div_src1  input  WIDTH  dividend; sampled with div_start.
- div_src2  input  WIDTH  divisor; sampled with div_start.
- div_busy  output  1  high whenever state != IDLE.
- div_done  output  1  one-cycle pulse; results valid in that cycle.
- div_quotient  output  WIDTH  quotient, goes to LO.
- div_remainder  output  WIDTH  remainder, goes to HI.

Behaviour:
- Reset is asynchronous, active-low, on `resetn`:
  - state = IDLE, counter = 0.
  - div_busy = 0, div_done = 0, div_quotient = 0, div_remainder = 0.
  - All internal working registers = 0.
- State machine has four states: IDLE, CALC, FIX, DONE.
- IDLE:
  - If div_start = 1 and div_cancel = 0, latch the operands and div_signed, then go to CALC.
  - Latching stores |src1| and |src2| (magnitudes), sign(src1), and sign(src1) ^ sign(src2).
  - In unsigned mode the magnitudes are the raw values and both stored signs are 0.
  - Counter = 0 on entry to CALC.
- CALC: restoring division, one quotient bit per cycle, MSB first.
  - Each cycle: partial remainder = (rem << 1) | next dividend bit.
  - If partial remainder >= divisor: subtract the divisor and shift in quotient bit 1; otherwise shift in 0.
  - Use a WIDTH+1-bit subtractor so the compare and subtract cannot overflow.
  - After exactly WIDTH cycles, go to FIX.
- FIX:
  - Negate the quotient if the stored quotient-sign is 1.
  - Negate the remainder if sign(src1) is 1.
  - Register both into div_quotient / div_remainder and go to DONE.
- DONE: div_done = 1 for this single cycle, then return to IDLE.
- Latency: div_start sampled at edge E0 → div_done high in the cycle after edge E0+WIDTH+1, i.e. 34 cycles for WIDTH = 32.
- div_busy:
  - Goes high in the cycle after E0 and stays high through CALC, FIX and DONE.
  - Goes low after the DONE cycle.
- Result hold: div_quotient and div_remainder keep their values after DONE until the next FIX update or a reset.
- div_start while busy (any non-IDLE state) is ignored. No queuing; upstream must stall.
- div_cancel:
  - In any non-IDLE state, return to IDLE on the next edge.
  - div_done is not pulsed and the output registers are not updated.
  - A start and a cancel in the same IDLE cycle: cancel wins, and the start is dropped.
- Divide by zero (src2 = 0), either mode:
  - Full latency still applies.
  - Result forced to quotient = all-ones, remainder = src1 (original, un-negated).
- Signed overflow: src1 = 0x8000_0000, src2 = 0xFFFF_FFFF gives quotient = 0x8000_0000, remainder = 0. This falls out of the magnitude arithmetic wrapping.
- Signed semantics truncate toward zero. The remainder carries the sign of the dividend (MIPS convention).
- Reset asserted mid-operation returns to the reset values immediately (asynchronously).

Decomposition:
- Shared execute-stage package holds:
  - The div state enum (IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3).
  - The WIDTH default constant.
  - A DIV_ZERO_Q constant (all-ones).
- One sub-module is natural: div_iter_step.
  - Combinational single restoring step.
  - Inputs: rem, divisor, next dividend bit.
  - Outputs: new rem, quotient bit.
  - Keeps the WIDTH+1-bit compare/subtract isolated for unit test and future radix-4 replacement.

Test Plan:
- Unsigned 100 / 7, start at cycle 0 → div_busy from cycle 1; div_done only in cycle 34 with Q = 14, R = 2.
- Signed 0xFFFF_FFF9 / 2 (-7/2) → Q = 0xFFFF_FFFD, R = 0xFFFF_FFFF. Signed 7 / 0xFFFF_FFFE (7/-2) → Q = 0xFFFF_FFFD, R = 1.
- Signed 0x8000_0000 / 0xFFFF_FFFF → Q = 0x8000_0000, R = 0. Unsigned 0x1234 / 0 → Q = 0xFFFF_FFFF, R = 0x1234, still at cycle 34.
- Start 100/7; at cycle 5 a second start 9/3 is presented (ignored); at cycle 10 assert div_cancel → IDLE at cycle 11, no div_done. Outputs still hold the previous result. A new start 9/3 at cycle 12 → div_done at cycle 46 with Q = 3, R = 0.
- div_start and div_cancel together in IDLE → no state change and div_busy stays 0. Then deassert resetn asynchronously mid-CALC → div_busy, div_done and outputs are 0 before the next clock edge.
- Back-to-back: start presented in the DONE cycle is ignored. Start in the following IDLE cycle is accepted. Exactly one div_done per accepted start.
